// File: rtl/pixel_accum_multi.sv
// Multi-channel running-sum accumulator: sums CHANNELS components per accepted sample,
// counts samples, tracks sticky per-channel overflow and hands totals off with valid/ready.
// Build option: define PIXEL_ACCUM_SATURATE_EN to clamp channel sums at all-ones instead of wrapping.
module pixel_accum_multi #(
    parameter int DATA_W   = 8,
    parameter int SUM_W    = 22,
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*SUM_W-1:0]  sum,
    output logic [CNT_W-1:0]           count,
    output logic [CHANNELS-1:0]        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Add with one extra bit so the carry out of the accumulator MSB is visible.
    function automatic logic [SUM_W:0] add_ext(input logic [SUM_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return {1'b0, a} + {{(SUM_W + 1 - DATA_W){1'b0}}, b};
    endfunction

    function automatic logic [SUM_W-1:0] wrap_or_sat(input logic [SUM_W:0] s);
`ifdef PIXEL_ACCUM_SATURATE_EN
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
`else
        return s[SUM_W-1:0];
`endif
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_out_valid;
    logic [SUM_W-1:0]      r_sum     [CHANNELS];
    logic [SUM_W-1:0]      w_sum_nxt [CHANNELS];
    logic [SUM_W:0]        w_add     [CHANNELS];
    logic [DATA_W-1:0]     w_chan    [CHANNELS];
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CHANNELS-1:0]   r_ovf;
    logic [CHANNELS-1:0]   w_ovf_nxt;
    logic                  w_accept;

    assign in_ready  = (r_state != DONE);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign overflow  = r_ovf;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign w_chan[c]                 = in_data[c*DATA_W +: DATA_W];
        assign w_add[c]                  = add_ext(r_sum[c], w_chan[c]);
        assign sum[c*SUM_W +: SUM_W]     = r_sum[c];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clear overrides every state transition and always lands in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear) begin
            w_state_nxt = IDLE;
        end
    end

    // IDLE acceptance loads a fresh frame; ACCUM acceptance adds into it.
    always_comb begin
        w_cnt_nxt = r_count;
        w_ovf_nxt = r_ovf;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum_nxt[c] = r_sum[c];
        end
        if (clear) begin
            w_cnt_nxt = '0;
            w_ovf_nxt = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                w_sum_nxt[c] = '0;
            end
        end else if (w_accept && (r_state == IDLE)) begin
            w_cnt_nxt = CNT_W'(1);
            w_ovf_nxt = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                w_sum_nxt[c] = {{(SUM_W - DATA_W){1'b0}}, w_chan[c]};
            end
        end else if (w_accept && (r_state == ACCUM)) begin
            w_cnt_nxt = sat_inc(r_count);
            for (int c = 0; c < CHANNELS; c++) begin
                w_sum_nxt[c] = wrap_or_sat(w_add[c]);
                w_ovf_nxt[c] = r_ovf[c] | w_add[c][SUM_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_ovf       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_sum[c] <= '0;
            end
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            r_count     <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                r_sum[c] <= w_sum_nxt[c];
            end
        end
    end

endmodule
